// File: rtl/vga_batalha_pkg.sv
// Shared constants and types for the Batalha Naval VGA overlays (640x480, 8x8 grid).
package vga_batalha_pkg;
  localparam logic [9:0] ORIGEM        = 10'd16;
  localparam logic [9:0] PASSO_X       = 10'd62;
  localparam logic [9:0] PASSO_Y       = 10'd57;
  localparam logic [9:0] LARGURA       = 10'd54;
  localparam logic [9:0] ALTURA        = 10'd49;
  localparam logic [9:0] LINHA_GATILHO = 10'd480;
  localparam logic [3:0] GRADE         = 4'd8;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    PRONTO  = 2'd2
  } estado_t;

  typedef logic [2:0] cor_t;
  localparam cor_t VERMELHO = 3'b100;
  localparam cor_t AMARELO  = 3'b110;
  localparam cor_t APAGADO  = 3'b000;
endpackage

// File: rtl/vga_mapa_celula.sv
// Combinational grid (X,Y) to pixel-rectangle converter; X/Y outside 1..8 yield vld=0.
module vga_mapa_celula #(
  parameter logic [9:0] ORIGEM  = vga_batalha_pkg::ORIGEM,
  parameter logic [9:0] PASSO_X = vga_batalha_pkg::PASSO_X,
  parameter logic [9:0] PASSO_Y = vga_batalha_pkg::PASSO_Y
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [9:0] esq,
  output logic [9:0] topo,
  output logic       vld
);
  import vga_batalha_pkg::*;

  logic [9:0] x_m1_s;
  logic [9:0] y_m1_s;

  // Products stay in 10 bits; out-of-range coordinates are masked by vld.
  always_comb begin
    x_m1_s = {6'd0, x} - 10'd1;
    y_m1_s = {6'd0, y} - 10'd1;
    esq    = ORIGEM + x_m1_s * PASSO_X;
    topo   = ORIGEM + y_m1_s * PASSO_Y;
    vld    = (x >= 4'd1) && (x <= GRADE) && (y >= 4'd1) && (y <= GRADE);
  end
endmodule

// File: rtl/vga_embarcacao_n.sv
// N-cell ship overlay: snapshots positions/hits at the frame trigger, loads one cell per cycle,
// draws a registered RGB. Optional hit-cell blinking under VGA_PISCA_ACERTO_EN.
module vga_embarcacao_n #(
  parameter int         N_CELULAS     = 5,
  parameter logic       COR_R         = 1'b1,
  parameter logic       COR_G         = 1'b1,
  parameter logic       COR_B         = 1'b0,
  parameter logic [9:0] LARGURA       = vga_batalha_pkg::LARGURA,
  parameter logic [9:0] ALTURA        = vga_batalha_pkg::ALTURA,
  parameter logic [9:0] PASSO_X       = vga_batalha_pkg::PASSO_X,
  parameter logic [9:0] PASSO_Y       = vga_batalha_pkg::PASSO_Y,
  parameter logic [9:0] ORIGEM        = vga_batalha_pkg::ORIGEM,
  parameter int         PISCA_QUADROS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     areaAtiva,
  input  logic [9:0]               linha,
  input  logic [9:0]               coluna,
  input  logic [8*N_CELULAS+2:0]   posicoesEmbarcacao,
  input  logic [N_CELULAS-1:0]     acertos,
  output logic                     rgb_r,
  output logic                     rgb_g,
  output logic                     rgb_b
);
  import vga_batalha_pkg::*;

  localparam int         W        = 8 * N_CELULAS + 3;
  localparam logic [2:0] K_ULTIMO = 3'(N_CELULAS - 1);

  estado_t      estado_q, estado_d;
  logic [2:0]   k_q, k_d;
  logic [W-1:0] pos_q, pos_d;
  logic [7:0]   hit_q, hit_d;
  logic [7:0]   quadro_q, quadro_d;
  logic [9:0]   esq_q [8];
  logic [9:0]   esq_d [8];
  logic [9:0]   topo_q [8];
  logic [9:0]   topo_d [8];
  logic [7:0]   vld_q, vld_d;
  cor_t         rgb_q, rgb_d;

  logic [3:0]   x_s [8];
  logic [3:0]   y_s [8];
  logic [7:0]   hit_in_s;
  logic [9:0]   esq_s, topo_s;
  logic         vld_s;
  logic         gatilho_s;
  logic         intacto_s, atingido_s, dentro_s, pisca_s;
  logic         unused_bits_s;

  // Unused cells are padded to 8 so the load index never leaves the tables.
  for (genvar g = 0; g < 8; g++) begin : g_celula
    if (g < N_CELULAS) begin : g_usada
      assign x_s[g]      = pos_q[8*g+3 +: 4];
      assign y_s[g]      = pos_q[8*g+7 +: 4];
      assign hit_in_s[g] = acertos[g];
    end else begin : g_vazia
      assign x_s[g]      = 4'd0;
      assign y_s[g]      = 4'd0;
      assign hit_in_s[g] = 1'b0;
    end
  end

  assign unused_bits_s = ^pos_q[2:0];
  assign gatilho_s     = (linha == LINHA_GATILHO) && (coluna == 10'd0);

  vga_mapa_celula #(
    .ORIGEM  (ORIGEM),
    .PASSO_X (PASSO_X),
    .PASSO_Y (PASSO_Y)
  ) u_mapa (
    .x    (x_s[k_q]),
    .y    (y_s[k_q]),
    .esq  (esq_s),
    .topo (topo_s),
    .vld  (vld_s)
  );

  // A trigger during CARREGA is ignored so a load always finishes on a consistent snapshot.
  always_comb begin
    estado_d = estado_q;
    k_d      = k_q;
    pos_d    = pos_q;
    hit_d    = hit_q;
    esq_d    = esq_q;
    topo_d   = topo_q;
    vld_d    = vld_q;
    quadro_d = gatilho_s ? quadro_q + 8'd1 : quadro_q;
    case (estado_q)
      OCIOSO, PRONTO: begin
        if (gatilho_s) begin
          estado_d = CARREGA;
          k_d      = 3'd0;
          pos_d    = posicoesEmbarcacao;
          hit_d    = hit_in_s;
        end else begin
          estado_d = estado_q;
        end
      end
      CARREGA: begin
        esq_d[k_q]  = esq_s;
        topo_d[k_q] = topo_s;
        vld_d[k_q]  = vld_s;
        if (k_q == K_ULTIMO) begin
          estado_d = PRONTO;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Strict inequalities leave the rectangle border undrawn; overlapping cells OR together.
  always_comb begin
    intacto_s  = 1'b0;
    atingido_s = 1'b0;
    dentro_s   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dentro_s = vld_q[i]
               && (coluna > esq_q[i])
               && ({1'b0, coluna} < ({1'b0, esq_q[i]} + {1'b0, LARGURA}))
               && (linha > topo_q[i])
               && ({1'b0, linha} < ({1'b0, topo_q[i]} + {1'b0, ALTURA}));
      atingido_s = atingido_s | (dentro_s & hit_q[i]);
      intacto_s  = intacto_s | (dentro_s & ~hit_q[i]);
    end
  end

`ifdef VGA_PISCA_ACERTO_EN
  logic [7:0] quociente_s;
  assign quociente_s = quadro_q / 8'(PISCA_QUADROS);
  assign pisca_s     = ~quociente_s[0];
`else
  assign pisca_s = 1'b1;
`endif

  // Output colour: hit cells win over intact ones, blanking forces black.
  always_comb begin
    if (!areaAtiva) begin
      rgb_d = APAGADO;
    end else if (atingido_s && pisca_s) begin
      rgb_d = VERMELHO;
    end else if (intacto_s) begin
      rgb_d = {COR_R, COR_G, COR_B};
    end else begin
      rgb_d = APAGADO;
    end
  end

  // State, shadow and cell-table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      k_q      <= 3'd0;
      pos_q    <= '0;
      hit_q    <= 8'd0;
      quadro_q <= 8'd0;
      vld_q    <= 8'd0;
      rgb_q    <= APAGADO;
      for (int i = 0; i < 8; i++) begin
        esq_q[i]  <= 10'd0;
        topo_q[i] <= 10'd0;
      end
    end else begin
      estado_q <= estado_d;
      k_q      <= k_d;
      pos_q    <= pos_d;
      hit_q    <= hit_d;
      quadro_q <= quadro_d;
      vld_q    <= vld_d;
      rgb_q    <= rgb_d;
      esq_q    <= esq_d;
      topo_q   <= topo_d;
    end
  end

  assign rgb_r = rgb_q[2];
  assign rgb_g = rgb_q[1];
  assign rgb_b = rgb_q[0];
endmodule

// File: tb/tb_vga_embarcacao_n.sv
// Self-checking bench for vga_embarcacao_n: constant vector table, hand sequences and a
// rectangle-level reference model driven with random ship layouts.
module tb_vga_embarcacao_n;
  localparam int N = 5;
  localparam int W = 8 * N + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         areaAtiva = 1'b0;
  logic [9:0]   linha = 10'd0;
  logic [9:0]   coluna = 10'd0;
  logic [W-1:0] pos = '0;
  logic [N-1:0] acertos = '0;
  logic         rgb_r, rgb_g, rgb_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_pos = '0;
  logic [N-1:0] m_hit = '0;
  bit           m_loaded = 1'b0;
  int           m_frame = 0;

  typedef struct {
    logic [9:0] c;
    logic [9:0] l;
    logic       a;
    logic [2:0] e;
    string      nm;
  } vec_t;
  vec_t tab[10];

  always #5 clk = ~clk;

  vga_embarcacao_n dut (
    .clk                (clk),
    .rst                (rst),
    .areaAtiva          (areaAtiva),
    .linha              (linha),
    .coluna             (coluna),
    .posicoesEmbarcacao (pos),
    .acertos            (acertos),
    .rgb_r              (rgb_r),
    .rgb_g              (rgb_g),
    .rgb_b              (rgb_b)
  );

  function automatic logic [W-1:0] make_pos(input int xs[N], input int ys[N]);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[8*i+3 +: 4] = 4'(xs[i]);
      v[8*i+7 +: 4] = 4'(ys[i]);
    end
    return v;
  endfunction

  // Reference: each valid cell is an open rectangle; hit beats intact.
  function automatic logic [2:0] modelo(input int c, input int l, input bit a);
    int x, y, esq, topo;
    bit hit, intact, on;
    hit = 1'b0;
    intact = 1'b0;
    if (!a || !m_loaded) return 3'b000;
    for (int i = 0; i < N; i++) begin
      x = int'(m_pos[8*i+3 +: 4]);
      y = int'(m_pos[8*i+7 +: 4]);
      if (x >= 1 && x <= 8 && y >= 1 && y <= 8) begin
        esq  = 16 + (x - 1) * 62;
        topo = 16 + (y - 1) * 57;
        if (c > esq && c < esq + 54 && l > topo && l < topo + 49) begin
          if (m_hit[i]) hit = 1'b1;
          else intact = 1'b1;
        end
      end
    end
`ifdef VGA_PISCA_ACERTO_EN
    on = ((m_frame / 16) % 2) == 0;
`else
    on = 1'b1;
`endif
    if (hit && on) return 3'b100;
    if (intact) return 3'b110;
    return 3'b000;
  endfunction

  task automatic chk(input int c, input int l, input bit a, input logic [2:0] exp, input string nm);
    coluna = 10'(c);
    linha = 10'(l);
    areaAtiva = a;
    @(posedge clk);
    #1;
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== exp) begin
      errors++;
      $display("FAIL %s: rgb=%b expected %b (coluna=%0d linha=%0d area=%0b)",
               nm, {rgb_r, rgb_g, rgb_b}, exp, c, l, a);
    end
  endtask

  task automatic chk_m(input int c, input int l, input bit a, input string nm);
    chk(c, l, a, modelo(c, l, a), nm);
  endtask

  task automatic trig(input logic [W-1:0] p, input logic [N-1:0] h);
    pos = p;
    acertos = h;
    linha = 10'd480;
    coluna = 10'd0;
    areaAtiva = 1'b0;
    @(posedge clk);
    #1;
    m_pos = p;
    m_hit = h;
    m_frame = (m_frame + 1) % 256;
    linha = 10'd481;
    coluna = 10'd1;
    repeat (N + 1) @(posedge clk);
    #1;
    m_loaded = 1'b1;
  endtask

  initial begin
    int xs[N];
    int ys[N];
    logic [W-1:0] p;
    logic [N-1:0] h;

    tab[0] = '{10'd100, 10'd150, 1'b1, 3'b110, "centro"};
    tab[1] = '{10'd78,  10'd150, 1'b1, 3'b000, "borda_esq"};
    tab[2] = '{10'd79,  10'd150, 1'b1, 3'b110, "dentro_esq"};
    tab[3] = '{10'd131, 10'd150, 1'b1, 3'b110, "dentro_dir"};
    tab[4] = '{10'd132, 10'd150, 1'b1, 3'b000, "borda_dir"};
    tab[5] = '{10'd100, 10'd130, 1'b1, 3'b000, "borda_topo"};
    tab[6] = '{10'd100, 10'd131, 1'b1, 3'b110, "dentro_topo"};
    tab[7] = '{10'd100, 10'd178, 1'b1, 3'b110, "dentro_base"};
    tab[8] = '{10'd100, 10'd179, 1'b1, 3'b000, "borda_base"};
    tab[9] = '{10'd100, 10'd150, 1'b0, 3'b000, "area_inativa"};

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 3'b000) begin
      errors++;
      $display("FAIL reset: rgb=%b expected 000", {rgb_r, rgb_g, rgb_b});
    end
    rst = 1'b0;
    chk(100, 150, 1'b1, 3'b000, "antes_da_carga");

    xs = '{2, 0, 0, 0, 0};
    ys = '{3, 0, 0, 0, 0};
    trig(make_pos(xs, ys), 5'b00000);
    for (int i = 0; i < 10; i++) chk(tab[i].c, tab[i].l, tab[i].a, tab[i].e, tab[i].nm);

    trig(make_pos(xs, ys), 5'b00001);
    chk(100, 150, 1'b1, 3'b100, "acerto");
    chk(100, 150, 1'b0, 3'b000, "acerto_inativo");

    xs = '{2, 0, 3, 8, 5};
    ys = '{3, 1, 9, 8, 5};
    trig(make_pos(xs, ys), 5'b00000);
    chk(460, 430, 1'b1, 3'b110, "cel3_8_8");
    chk(30, 30, 1'b1, 3'b000, "cel1_x0");
    chk(150, 475, 1'b1, 3'b000, "cel2_y9");
    chk_m(300, 270, 1'b1, "cel4_5_5");

    xs = '{1, 1, 1, 1, 1};
    ys = '{1, 2, 3, 4, 5};
    p = make_pos(xs, ys);
    pos = p;
    chk(460, 430, 1'b1, 3'b110, "meio_quadro_antigo");
    chk(30, 30, 1'b1, 3'b000, "meio_quadro_novo");
    trig(p, 5'b00000);
    chk(460, 430, 1'b1, 3'b000, "apos_gatilho_antigo");
    chk(30, 30, 1'b1, 3'b110, "apos_gatilho_novo");

    // Reset while the table is being loaded.
    linha = 10'd480;
    coluna = 10'd0;
    areaAtiva = 1'b0;
    @(posedge clk);
    #1;
    coluna = 10'd30;
    linha = 10'd30;
    areaAtiva = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 3'b000) begin
      errors++;
      $display("FAIL rst_carga: rgb=%b expected 000", {rgb_r, rgb_g, rgb_b});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_loaded = 1'b0;
    m_frame = 0;
    repeat (10) @(posedge clk);
    #1;
    chk(30, 30, 1'b1, 3'b000, "apos_rst");
    chk_m(100, 150, 1'b1, "apos_rst_modelo");
    trig(p, 5'b00000);
    chk(30, 30, 1'b1, 3'b110, "recarga");

    xs = '{2, 0, 0, 8, 0};
    ys = '{3, 0, 0, 8, 0};
    for (int f = 0; f < 34; f++) begin
      trig(make_pos(xs, ys), 5'b00001);
      chk_m(100, 150, 1'b1, "pisca_acerto");
      chk(460, 430, 1'b1, 3'b110, "pisca_intacto");
    end

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) begin
        xs[i] = int'($urandom_range(0, 9));
        ys[i] = int'($urandom_range(0, 9));
      end
      h = N'($urandom);
      trig(make_pos(xs, ys), h);
      for (int k = 0; k < 40; k++) begin
        int c, l;
        bit a;
        if (k % 2 == 0) begin
          c = int'($urandom_range(0, 639));
          l = int'($urandom_range(0, 479));
        end else begin
          c = 14 + int'($urandom_range(0, 7)) * 62 + int'($urandom_range(0, 58));
          l = 14 + int'($urandom_range(0, 7)) * 57 + int'($urandom_range(0, 53));
        end
        a = ($urandom_range(0, 7) != 0);
        chk_m(c, l, a, "aleatorio");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
